vexriscv_dbus_axil_bridge: RTL and testbench
============================================

Name: vexriscv_dbus_axil_bridge

Overview:
Converts the VexRiscv simple data-bus command/response interface into a single-outstanding AXI4-Lite master. It sits between the core's dBus and the M_DATA_AXI port of the VexRiscv IP, upstream of the AXI slave/interconnect. Writes and reads each complete with one response pulse, and a sticky ERROR flag is raised on any non-OKAY response.

Parameters:
ADDR_WIDTH, 32, CMD/AXI address width
TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with VEXRISCV_AXI_TIMEOUT_EN)

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
CMD_VALID  in  1  core command valid
CMD_READY  out  1  bridge accepts command (high only in IDLE)
CMD_WR  in  1  1=write, 0=read
CMD_ADDR  in  ADDR_WIDTH  byte address
CMD_DATA  in  32  write data
CMD_MASK  in  4  byte enables
RSP_VALID  out  1  one-cycle response pulse
RSP_DATA  out  32  read data (0 for writes)
RSP_ERROR  out  1  response was non-OKAY (qualified by RSP_VALID)
M_AXI_AWADDR  out  ADDR_WIDTH  write address
M_AXI_AWVALID  out  1  write address valid
M_AXI_AWREADY  in  1  write address ready
M_AXI_WDATA  out  32  write data
M_AXI_WSTRB  out  4  write strobes
M_AXI_WVALID  out  1  write data valid
M_AXI_WREADY  in  1  write data ready
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1  write response valid
M_AXI_BREADY  out  1  write response ready
M_AXI_ARADDR  out  ADDR_WIDTH  read address
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address ready
M_AXI_RDATA  in  32  read data
M_AXI_RRESP  in  2  read response
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready
ERROR  out  1  sticky: set on any non-OKAY response, cleared only by reset

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0 (CMD_READY=0 during ARESET, 1 from the first ACLK edge after release); address/data registers 0.
- FSM: IDLE -> WR_REQ | RD_REQ -> WR_RESP | RD_RESP -> DONE -> IDLE.
- IDLE: CMD_READY=1. CMD_VALID&CMD_READY at edge N latches addr/data/mask/wr. AWVALID+WVALID (write) or ARVALID (read) are asserted from cycle N+1, registered.
- WR_REQ: AW and W are independent. Each VALID drops the cycle after its own handshake; internal aw_done/w_done flags. Same-cycle AWREADY and WREADY are legal. Leave for WR_RESP when both flags are set. VALIDs and payload never change while waiting for READY.
- WR_RESP: BREADY=1; on BVALID latch err=(BRESP!=2'b00) -> DONE.
- RD_REQ: ARVALID held until ARREADY -> RD_RESP. RD_RESP: RREADY=1; on RVALID latch RDATA and err=(RRESP!=0) -> DONE.
- DONE: RSP_VALID=1 for exactly one cycle; RSP_DATA/RSP_ERROR valid this cycle; ERROR|=err. Next cycle IDLE.
- Minimum turnaround with zero-wait slave: CMD accept at N, AXI handshake N+1, B/R N+2, RSP_VALID N+3, next CMD_READY N+4.
- Only one transaction outstanding. CMD_VALID outside IDLE is ignored (CMD_READY=0). The core must hold the command.
- BVALID/RVALID arriving in a state not expecting them: not accepted (ready low).

Optional Feature:
VEXRISCV_AXI_TIMEOUT_EN: adds a cycle counter that is cleared on entering WR_REQ/RD_REQ and on each handshake. If it reaches TIMEOUT_CYCLES in any non-IDLE/non-DONE state: drop all AXI VALID/READY, go to DONE with RSP_ERROR=1, RSP_DATA=0, ERROR=1. Without the macro there is no counter and the bridge waits indefinitely.

Test Plan:
- Read 0x0000_0010, slave returns 0xDEADBEEF OKAY with 0 wait -> ARADDR=0x10, RSP_VALID one pulse at N+3, RSP_DATA=0xDEADBEEF, RSP_ERROR=0, ERROR=0.
- Write 0x20 data 0x12345678 mask 4'b0101, AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 3 cycles, WSTRB=0101, a single RSP_VALID after BVALID.
- Read with RRESP=2'b10 (SLVERR) -> RSP_ERROR=1, ERROR=1; a following OKAY write gives RSP_ERROR=0 and ERROR stays 1.
- CMD_VALID held high during a pending read -> CMD_READY=0, no second ARVALID until RSP_VALID+1.
- Assert ARESET while in WR_RESP -> all outputs 0 immediately; after release CMD_READY=1 and no RSP_VALID is emitted for the aborted write.
- (VEXRISCV_AXI_TIMEOUT_EN, TIMEOUT_CYCLES=16) ARREADY tied 0 -> ARVALID drops after 16 cycles, RSP_VALID with RSP_ERROR=1, ERROR=1.

Source files
------------

// File: rtl/vexriscv_dbus_axil_bridge_if.sv
// Bundles the VexRiscv dBus command/response signals and the AXI4-Lite master
// channels. The bridge uses the master modport; the core and slave side use slave.
interface vexriscv_dbus_axil_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic                  CMD_WR;
  logic [ADDR_WIDTH-1:0] CMD_ADDR;
  logic [31:0]           CMD_DATA;
  logic [3:0]            CMD_MASK;
  logic                  RSP_VALID;
  logic [31:0]           RSP_DATA;
  logic                  RSP_ERROR;
  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic                  M_AXI_AWVALID;
  logic                  M_AXI_AWREADY;
  logic [31:0]           M_AXI_WDATA;
  logic [3:0]            M_AXI_WSTRB;
  logic                  M_AXI_WVALID;
  logic                  M_AXI_WREADY;
  logic [1:0]            M_AXI_BRESP;
  logic                  M_AXI_BVALID;
  logic                  M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [31:0]           M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport master (
    input  CMD_VALID, CMD_WR, CMD_ADDR, CMD_DATA, CMD_MASK,
    output CMD_READY, RSP_VALID, RSP_DATA, RSP_ERROR,
    output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    output CMD_VALID, CMD_WR, CMD_ADDR, CMD_DATA, CMD_MASK,
    input  CMD_READY, RSP_VALID, RSP_DATA, RSP_ERROR,
    input  M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/vexriscv_dbus_axil_bridge.sv
// Single-outstanding bridge from the VexRiscv simple dBus to an AXI4-Lite master.
// Define VEXRISCV_AXI_TIMEOUT_EN to add a watchdog that aborts stalled transactions.
module vexriscv_dbus_axil_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  vexriscv_dbus_axil_bridge_if.master     bus,
  output logic                            ERROR
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_WR_RESP = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [31:0]           rdata_q;
  logic [3:0]            mask_q;
  logic                  awvalid_q, wvalid_q, arvalid_q;
  logic                  aw_done, w_done;
  logic                  err_q, error_q, ready_en;
  logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs, any_hs;
  logic                  timeout;

  assign aw_hs  = awvalid_q & bus.M_AXI_AWREADY;
  assign w_hs   = wvalid_q & bus.M_AXI_WREADY;
  assign ar_hs  = arvalid_q & bus.M_AXI_ARREADY;
  assign b_hs   = (state == S_WR_RESP) & bus.M_AXI_BVALID;
  assign r_hs   = (state == S_RD_RESP) & bus.M_AXI_RVALID;
  assign any_hs = aw_hs | w_hs | ar_hs | b_hs | r_hs;

`ifdef VEXRISCV_AXI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  // Counts stalled cycles of the current phase; any handshake restarts the window.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)
      tmo_cnt <= '0;
    else if (state == S_IDLE || state == S_DONE || any_hs)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + CW'(1);
  end

  assign timeout = (state != S_IDLE) && (state != S_DONE) && !any_hs &&
                   (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      mask_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      err_q     <= 1'b0;
      error_q   <= 1'b0;
      ready_en  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (timeout) begin
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        arvalid_q <= 1'b0;
        rdata_q   <= '0;
        err_q     <= 1'b1;
        error_q   <= 1'b1;
        state     <= S_DONE;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.CMD_VALID && ready_en) begin
              addr_q  <= bus.CMD_ADDR;
              data_q  <= bus.CMD_DATA;
              mask_q  <= bus.CMD_MASK;
              rdata_q <= '0;
              err_q   <= 1'b0;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              if (bus.CMD_WR) begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                state     <= S_WR_REQ;
              end else begin
                arvalid_q <= 1'b1;
                state     <= S_RD_REQ;
              end
            end
          end
          // AW and W complete independently, possibly in the same cycle.
          S_WR_REQ: begin
            if (aw_hs) begin
              awvalid_q <= 1'b0;
              aw_done   <= 1'b1;
            end
            if (w_hs) begin
              wvalid_q <= 1'b0;
              w_done   <= 1'b1;
            end
            if ((aw_done || aw_hs) && (w_done || w_hs))
              state <= S_WR_RESP;
          end
          S_WR_RESP: begin
            if (b_hs) begin
              err_q   <= (bus.M_AXI_BRESP != 2'b00);
              error_q <= error_q | (bus.M_AXI_BRESP != 2'b00);
              state   <= S_DONE;
            end
          end
          S_RD_REQ: begin
            if (ar_hs) begin
              arvalid_q <= 1'b0;
              state     <= S_RD_RESP;
            end
          end
          S_RD_RESP: begin
            if (r_hs) begin
              rdata_q <= bus.M_AXI_RDATA;
              err_q   <= (bus.M_AXI_RRESP != 2'b00);
              error_q <= error_q | (bus.M_AXI_RRESP != 2'b00);
              state   <= S_DONE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.CMD_READY     = (state == S_IDLE) & ready_en;
  assign bus.RSP_VALID     = (state == S_DONE);
  assign bus.RSP_DATA      = rdata_q;
  assign bus.RSP_ERROR     = err_q & (state == S_DONE);
  assign bus.M_AXI_AWADDR  = addr_q;
  assign bus.M_AXI_AWVALID = awvalid_q;
  assign bus.M_AXI_WDATA   = data_q;
  assign bus.M_AXI_WSTRB   = mask_q;
  assign bus.M_AXI_WVALID  = wvalid_q;
  assign bus.M_AXI_BREADY  = (state == S_WR_RESP);
  assign bus.M_AXI_ARADDR  = addr_q;
  assign bus.M_AXI_ARVALID = arvalid_q;
  assign bus.M_AXI_RREADY  = (state == S_RD_RESP);
  assign ERROR             = error_q;

endmodule

// File: tb/tb_vexriscv_dbus_axil_bridge.sv
// Directed bench for vexriscv_dbus_axil_bridge; the watchdog scenario runs only
// when VEXRISCV_AXI_TIMEOUT_EN is defined.
module tb_vexriscv_dbus_axil_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic error;
  int   total = 0;
  int   bad   = 0;

  vexriscv_dbus_axil_bridge_if #(.ADDR_WIDTH(32)) bus ();

  vexriscv_dbus_axil_bridge #(
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus.master),
    .ERROR  (error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_slave();
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_BRESP   = 2'b00;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RVALID  = 1'b0;
    bus.M_AXI_RRESP   = 2'b00;
    bus.M_AXI_RDATA   = 32'h0;
  endtask

  // Presents one command for a single cycle; the caller must be in IDLE.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask);
    bus.CMD_VALID = 1'b1;
    bus.CMD_WR    = wr;
    bus.CMD_ADDR  = addr;
    bus.CMD_DATA  = data;
    bus.CMD_MASK  = mask;
    tick();
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.CMD_READY !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=0", bus.CMD_READY); end
    total++; if (bus.RSP_VALID !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.RSP_VALID); end
    total++; if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID} !== 3'b000) begin bad++; $display("FAIL rst_valids got=%b exp=000", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b exp=0", error); end
    rst = 1'b0;
    #2;
    total++; if (bus.CMD_READY !== 1'b0) begin bad++; $display("FAIL rst_release_ready got=%b exp=0", bus.CMD_READY); end
    tick();
    total++; if (bus.CMD_READY !== 1'b1) begin bad++; $display("FAIL rst_first_edge_ready got=%b exp=1", bus.CMD_READY); end
  endtask

  task automatic test_read_ok();
    quiet_slave();
    bus.M_AXI_ARREADY = 1'b1;
    issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    total++; if (bus.M_AXI_ARVALID !== 1'b1) begin bad++; $display("FAIL rd_arvalid got=%b exp=1", bus.M_AXI_ARVALID); end
    total++; if (bus.M_AXI_ARADDR !== 32'h10) begin bad++; $display("FAIL rd_araddr got=%h exp=00000010", bus.M_AXI_ARADDR); end
    total++; if (bus.CMD_READY !== 1'b0) begin bad++; $display("FAIL rd_busy_ready got=%b exp=0", bus.CMD_READY); end
    bus.M_AXI_RVALID = 1'b1;
    bus.M_AXI_RDATA  = 32'hDEAD_BEEF;
    tick();
    total++; if ({bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.RSP_VALID} !== 3'b010) begin bad++; $display("FAIL rd_n2 got=%b exp=010", {bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.RSP_VALID}); end
    tick();
    bus.M_AXI_RVALID = 1'b0;
    total++; if (bus.RSP_VALID !== 1'b1) begin bad++; $display("FAIL rd_rsp_valid got=%b exp=1", bus.RSP_VALID); end
    total++; if (bus.RSP_DATA !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_rsp_data got=%h exp=deadbeef", bus.RSP_DATA); end
    total++; if ({bus.RSP_ERROR, error} !== 2'b00) begin bad++; $display("FAIL rd_err got=%b exp=00", {bus.RSP_ERROR, error}); end
    tick();
    total++; if ({bus.RSP_VALID, bus.CMD_READY} !== 2'b01) begin bad++; $display("FAIL rd_turnaround got=%b exp=01", {bus.RSP_VALID, bus.CMD_READY}); end
  endtask

  task automatic test_write_delayed_aw();
    int aw_cycles;
    quiet_slave();
    bus.M_AXI_WREADY = 1'b1;
    issue(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0101);
    total++; if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID} !== 2'b11) begin bad++; $display("FAIL wr_valids got=%b exp=11", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID}); end
    total++; if (bus.M_AXI_AWADDR !== 32'h20) begin bad++; $display("FAIL wr_awaddr got=%h exp=00000020", bus.M_AXI_AWADDR); end
    total++; if (bus.M_AXI_WDATA !== 32'h1234_5678) begin bad++; $display("FAIL wr_wdata got=%h exp=12345678", bus.M_AXI_WDATA); end
    total++; if (bus.M_AXI_WSTRB !== 4'b0101) begin bad++; $display("FAIL wr_wstrb got=%b exp=0101", bus.M_AXI_WSTRB); end
    aw_cycles = 1;
    tick();
    total++; if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID} !== 2'b10) begin bad++; $display("FAIL wr_w_drop got=%b exp=10", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID}); end
    if (bus.M_AXI_AWVALID === 1'b1) aw_cycles++;
    tick();
    if (bus.M_AXI_AWVALID === 1'b1) aw_cycles++;
    bus.M_AXI_AWREADY = 1'b1;
    tick();
    bus.M_AXI_AWREADY = 1'b0;
    total++; if (aw_cycles !== 3) begin bad++; $display("FAIL wr_aw_hold got=%0d exp=3", aw_cycles); end
    total++; if ({bus.M_AXI_AWVALID, bus.M_AXI_BREADY, bus.RSP_VALID} !== 3'b010) begin bad++; $display("FAIL wr_resp_state got=%b exp=010", {bus.M_AXI_AWVALID, bus.M_AXI_BREADY, bus.RSP_VALID}); end
    bus.M_AXI_BVALID = 1'b1;
    tick();
    bus.M_AXI_BVALID = 1'b0;
    total++; if ({bus.RSP_VALID, bus.RSP_ERROR} !== 2'b10) begin bad++; $display("FAIL wr_rsp got=%b exp=10", {bus.RSP_VALID, bus.RSP_ERROR}); end
    total++; if (bus.RSP_DATA !== 32'h0) begin bad++; $display("FAIL wr_rsp_data got=%h exp=00000000", bus.RSP_DATA); end
    tick();
    total++; if (bus.RSP_VALID !== 1'b0) begin bad++; $display("FAIL wr_single_pulse got=%b exp=0", bus.RSP_VALID); end
  endtask

  task automatic test_slverr_then_ok();
    quiet_slave();
    bus.M_AXI_ARREADY = 1'b1;
    issue(1'b0, 32'h0000_0030, 32'h0, 4'h0);
    bus.M_AXI_RVALID = 1'b1;
    bus.M_AXI_RRESP  = 2'b10;
    bus.M_AXI_RDATA  = 32'h0000_0055;
    tick();
    tick();
    bus.M_AXI_RVALID = 1'b0;
    bus.M_AXI_RRESP  = 2'b00;
    total++; if ({bus.RSP_VALID, bus.RSP_ERROR} !== 2'b11) begin bad++; $display("FAIL slverr_rsp got=%b exp=11", {bus.RSP_VALID, bus.RSP_ERROR}); end
    tick();
    total++; if (error !== 1'b1) begin bad++; $display("FAIL slverr_sticky got=%b exp=1", error); end
    quiet_slave();
    bus.M_AXI_AWREADY = 1'b1;
    bus.M_AXI_WREADY  = 1'b1;
    issue(1'b1, 32'h0000_0034, 32'hCAFE_0001, 4'b1111);
    tick();
    total++; if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY} !== 3'b001) begin bad++; $display("FAIL ok_wr_hs got=%b exp=001", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY}); end
    bus.M_AXI_BVALID = 1'b1;
    tick();
    bus.M_AXI_BVALID = 1'b0;
    total++; if ({bus.RSP_VALID, bus.RSP_ERROR, error} !== 3'b101) begin bad++; $display("FAIL ok_wr_rsp got=%b exp=101", {bus.RSP_VALID, bus.RSP_ERROR, error}); end
    tick();
    total++; if (error !== 1'b1) begin bad++; $display("FAIL ok_wr_sticky got=%b exp=1", error); end
  endtask

  task automatic test_cmd_hold();
    quiet_slave();
    bus.CMD_VALID = 1'b1;
    bus.CMD_WR    = 1'b0;
    bus.CMD_ADDR  = 32'h0000_0040;
    tick();
    total++; if ({bus.CMD_READY, bus.M_AXI_ARVALID} !== 2'b01) begin bad++; $display("FAIL hold_accept got=%b exp=01", {bus.CMD_READY, bus.M_AXI_ARVALID}); end
    tick();
    total++; if ({bus.CMD_READY, bus.M_AXI_ARVALID} !== 2'b01) begin bad++; $display("FAIL hold_wait got=%b exp=01", {bus.CMD_READY, bus.M_AXI_ARVALID}); end
    bus.M_AXI_ARREADY = 1'b1;
    tick();
    total++; if ({bus.CMD_READY, bus.M_AXI_ARVALID} !== 2'b00) begin bad++; $display("FAIL hold_ar_done got=%b exp=00", {bus.CMD_READY, bus.M_AXI_ARVALID}); end
    tick();
    total++; if ({bus.CMD_READY, bus.M_AXI_ARVALID, bus.RSP_VALID} !== 3'b000) begin bad++; $display("FAIL hold_r_wait got=%b exp=000", {bus.CMD_READY, bus.M_AXI_ARVALID, bus.RSP_VALID}); end
    bus.M_AXI_RVALID = 1'b1;
    bus.M_AXI_RDATA  = 32'hA5A5_A5A5;
    tick();
    bus.M_AXI_RVALID = 1'b0;
    total++; if ({bus.RSP_VALID, bus.CMD_READY, bus.M_AXI_ARVALID} !== 3'b100) begin bad++; $display("FAIL hold_done got=%b exp=100", {bus.RSP_VALID, bus.CMD_READY, bus.M_AXI_ARVALID}); end
    total++; if (bus.RSP_DATA !== 32'hA5A5_A5A5) begin bad++; $display("FAIL hold_rdata got=%h exp=a5a5a5a5", bus.RSP_DATA); end
    tick();
    total++; if ({bus.CMD_READY, bus.M_AXI_ARVALID} !== 2'b10) begin bad++; $display("FAIL hold_idle got=%b exp=10", {bus.CMD_READY, bus.M_AXI_ARVALID}); end
    tick();
    bus.CMD_VALID = 1'b0;
    total++; if (bus.M_AXI_ARVALID !== 1'b1) begin bad++; $display("FAIL hold_second_ar got=%b exp=1", bus.M_AXI_ARVALID); end
    tick();
    bus.M_AXI_RVALID = 1'b1;
    tick();
    bus.M_AXI_RVALID = 1'b0;
    total++; if (bus.RSP_VALID !== 1'b1) begin bad++; $display("FAIL hold_second_rsp got=%b exp=1", bus.RSP_VALID); end
    tick();
  endtask

  task automatic test_reset_in_wr_resp();
    int pulses;
    quiet_slave();
    bus.M_AXI_AWREADY = 1'b1;
    bus.M_AXI_WREADY  = 1'b1;
    issue(1'b1, 32'h0000_0050, 32'h0BAD_F00D, 4'b1100);
    tick();
    total++; if (bus.M_AXI_BREADY !== 1'b1) begin bad++; $display("FAIL abort_in_wr_resp got=%b exp=1", bus.M_AXI_BREADY); end
    rst = 1'b1;
    #1;
    total++; if ({bus.M_AXI_BREADY, bus.CMD_READY, bus.RSP_VALID, bus.M_AXI_AWVALID, error} !== 5'b00000) begin bad++; $display("FAIL abort_async_outs got=%b exp=00000", {bus.M_AXI_BREADY, bus.CMD_READY, bus.RSP_VALID, bus.M_AXI_AWVALID, error}); end
    total++; if (bus.M_AXI_AWADDR !== 32'h0) begin bad++; $display("FAIL abort_addr_clr got=%h exp=00000000", bus.M_AXI_AWADDR); end
    tick();
    rst = 1'b0;
    quiet_slave();
    tick();
    total++; if (bus.CMD_READY !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", bus.CMD_READY); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.RSP_VALID === 1'b1) pulses++;
      tick();
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL abort_no_rsp got=%0d exp=0", pulses); end
  endtask

`ifdef VEXRISCV_AXI_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    quiet_slave();
    issue(1'b0, 32'h0000_0060, 32'h0, 4'h0);
    n = 0;
    while (bus.M_AXI_ARVALID === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    total++; if (n !== 16) begin bad++; $display("FAIL tmo_ar_cycles got=%0d exp=16", n); end
    total++; if ({bus.RSP_VALID, bus.RSP_ERROR, error} !== 3'b111) begin bad++; $display("FAIL tmo_rsp got=%b exp=111", {bus.RSP_VALID, bus.RSP_ERROR, error}); end
    total++; if (bus.RSP_DATA !== 32'h0) begin bad++; $display("FAIL tmo_rdata got=%h exp=00000000", bus.RSP_DATA); end
    tick();
    total++; if ({bus.CMD_READY, error} !== 2'b11) begin bad++; $display("FAIL tmo_idle got=%b exp=11", {bus.CMD_READY, error}); end
  endtask
`endif

  initial begin
    bus.CMD_VALID = 1'b0;
    bus.CMD_WR    = 1'b0;
    bus.CMD_ADDR  = 32'h0;
    bus.CMD_DATA  = 32'h0;
    bus.CMD_MASK  = 4'h0;
    quiet_slave();
    test_reset();
    test_read_ok();
    test_write_delayed_aw();
    test_slverr_then_ok();
    test_cmd_hold();
    test_reset_in_wr_resp();
`ifdef VEXRISCV_AXI_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
